// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared types for the multi-channel acquisition engine
// Contents: acq_state_t, the capture FSM state encoding.
package acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } acq_state_t;

endpackage

// File: rtl/acq_decim.sv
// rtl/acq_decim.sv - decimation counter, keeps 1 of (decim+1) strobes
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - restart the count so the next strobe is kept
//   decim     - ratio minus one
//   strobe    - a sample is offered this cycle
//   keep      - the offered sample is kept (combinational)
module acq_decim
    import acq_pkg::*;
#(
    parameter int DECW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [DECW-1:0] decim,
    input  logic            strobe,
    output logic            keep
);

    logic [DECW-1:0] cnt;

    assign keep = strobe && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (strobe) begin
            cnt <= (cnt == decim) ? '0 : cnt + DECW'(1);
        end
    end

endmodule

// File: rtl/acq_capture_mc.sv
// rtl/acq_capture_mc.sv - multi-channel triggered ADC record capture into BRAMs
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready - NCH sample lanes, lane c at [c*DW +: DW]; never stalled
//   ch_en, length, decim     - record configuration, latched on arm
//   arm, trigger             - single-cycle control pulses
//   bram_we/addr/din         - per-buffer write port, shared address
//   busy, done, wcount       - progress status
//   misalign, trig_lost      - sticky error flags, cleared on arm
module acq_capture_mc
    import acq_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int DW   = 128,
    parameter int AW   = 12,
    parameter int DECW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] s_axis_tdata,
    input  logic [NCH-1:0]    s_axis_tvalid,
    output logic [NCH-1:0]    s_axis_tready,
    input  logic [NCH-1:0]    ch_en,
    input  logic [AW:0]       length,
    input  logic [DECW-1:0]   decim,
    input  logic              arm,
    input  logic              trigger,
    output logic [NCH-1:0]    bram_we,
    output logic [AW-1:0]     bram_addr,
    output logic [NCH*DW-1:0] bram_din,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       wcount,
    output logic              misalign,
    output logic              trig_lost
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    acq_state_t state, state_nx;

    logic [NCH-1:0]    en_q;
    logic [AW:0]       len_q;
    logic [DECW-1:0]   dec_q;
    logic [AW:0]       wcnt;
    logic              wr_pend;
    logic [NCH*DW-1:0] data_q;
    logic              mis_q;
    logic              tl_q;

    logic [AW:0] len_clamp;
    logic        capturing;
    logic        start;
    logic        all_v;
    logic        any_v;
    logic        strobe;
    logic        keep;
    logic        room;
    logic        take;
    logic        last_wr;

    // Lengths beyond the buffer depth are clamped so a record never wraps.
    assign len_clamp = (length > DEPTH_W) ? DEPTH_W : length;
    assign capturing = (state == ST_CAPTURE);
    assign start     = (state == ST_ARMED) && trigger && !arm;

    // Disabled lanes are forced valid so they do not gate the strobe.
    assign all_v  = &(s_axis_tvalid | ~en_q);
    assign any_v  = |(s_axis_tvalid & en_q);
    assign strobe = capturing && ((en_q == '0) ? s_axis_tvalid[0] : all_v);

    acq_decim #(.DECW(DECW)) u_decim (
        .clk    (clk),
        .rst    (rst),
        .load   (arm || start),
        .decim  (dec_q),
        .strobe (strobe),
        .keep   (keep)
    );

    // Counting the write still in flight stops the sample after the final
    // word from being taken in the same cycle that word is written.
    assign room    = (wcnt + {{AW{1'b0}}, wr_pend}) < len_q;
    assign take    = keep && room && !arm;
    assign last_wr = capturing && wr_pend && ((wcnt + (AW + 1)'(1)) == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_ARMED:   if (trigger) state_nx = ST_CAPTURE;
            ST_CAPTURE: if (last_wr) state_nx = ST_DONE;
            default:    state_nx = state;
        endcase
        if (arm) begin
            state_nx = (len_clamp == '0) ? ST_DONE : ST_ARMED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= '0;
            len_q   <= '0;
            dec_q   <= '0;
            wcnt    <= '0;
            wr_pend <= 1'b0;
            data_q  <= '0;
            mis_q   <= 1'b0;
            tl_q    <= 1'b0;
        end else begin
            data_q  <= s_axis_tdata;
            wr_pend <= take;
            if (arm) begin
                en_q  <= ch_en;
                len_q <= len_clamp;
                dec_q <= decim;
                wcnt  <= '0;
                mis_q <= 1'b0;
                tl_q  <= 1'b0;
            end else begin
                if (wr_pend) begin
                    wcnt <= wcnt + (AW + 1)'(1);
                end
                if (capturing && any_v && !all_v) begin
                    mis_q <= 1'b1;
                end
                if (capturing && trigger) begin
                    tl_q <= 1'b1;
                end
            end
        end
    end

    assign s_axis_tready = '1;
    assign bram_we       = wr_pend ? en_q : '0;
    assign bram_addr     = wcnt[AW-1:0];
    assign bram_din      = data_q;
    assign busy          = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign done          = (state == ST_DONE);
    assign wcount        = wcnt;
    assign misalign      = mis_q;
    assign trig_lost     = tl_q;

endmodule
